// File: rtl/ram_arb_pkg.sv
// Shared defaults and requester-index helpers for the two-requester RAM port arbiter.
package ram_arb_pkg;
    localparam int NREQ_DEF   = 2;
    localparam int ADDR_W_DEF = 5;
    localparam int DATA_W_DEF = 32;

    typedef logic req_idx_t;

    function automatic req_idx_t other_req(input req_idx_t idx);
        return ~idx;
    endfunction
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: one grant per cycle, pointer moves past the winner.
module rr_arbiter2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);
    req_idx_t ptr_reg;
    req_idx_t ptr_next;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr_reg <= 1'b0;
        end else begin
            ptr_reg <= ptr_next;
        end
    end

    always_comb begin
        gnt      = req;
        ptr_next = ptr_reg;
        if (req == 2'b11) begin
            gnt = (ptr_reg == 1'b0) ? 2'b01 : 2'b10;
        end
        // gnt[1] is the index of the winner when any grant is issued
        if (gnt != 2'b00) begin
            ptr_next = other_req(gnt[1]);
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates two requesters onto a 1R/1W registered RAM, stalling reads that
// would race a write still in flight to the same address.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ   = NREQ_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_0,
    input  logic [ADDR_W-1:0] rd_addr_0,
    output logic              rd_gnt_0,
    output logic              rd_rvalid_0,
    output logic [DATA_W-1:0] rd_rdata_0,
    input  logic              rd_req_1,
    input  logic [ADDR_W-1:0] rd_addr_1,
    output logic              rd_gnt_1,
    output logic              rd_rvalid_1,
    output logic [DATA_W-1:0] rd_rdata_1,
    input  logic              wr_req_0,
    input  logic [ADDR_W-1:0] wr_addr_0,
    input  logic [DATA_W-1:0] wr_data_0,
    output logic              wr_gnt_0,
    input  logic              wr_req_1,
    input  logic [ADDR_W-1:0] wr_addr_1,
    input  logic [DATA_W-1:0] wr_data_1,
    output logic              wr_gnt_1,
    output logic [ADDR_W-1:0] raddr_0,
    output logic              ren_0,
    input  logic [DATA_W-1:0] rdata_0,
    output logic [ADDR_W-1:0] waddr_0,
    output logic [DATA_W-1:0] wdata_0,
    output logic              wen_0
);
    logic [NREQ-1:0]   rd_req_v;
    logic [NREQ-1:0]   wr_req_v;
    logic [NREQ-1:0]   rd_elig;
    logic [NREQ-1:0]   rd_gnt_raw;
    logic [NREQ-1:0]   wr_gnt_raw;
    logic [ADDR_W-1:0] rd_addr_a  [NREQ];
    logic [ADDR_W-1:0] wr_addr_a  [NREQ];
    logic [DATA_W-1:0] wr_data_a  [NREQ];
    logic [DATA_W-1:0] rd_rdata_a [NREQ];

    logic              wen_raw;
    logic [ADDR_W-1:0] waddr_raw;
    logic [DATA_W-1:0] wdata_raw;
    logic [ADDR_W-1:0] raddr_raw;

    logic [NREQ-1:0]   rv_reg;
    logic [NREQ-1:0]   rv_next;
    logic              lw_valid_reg;
    logic              lw_valid_next;
    logic [ADDR_W-1:0] lw_addr_reg;
    logic [ADDR_W-1:0] lw_addr_next;

    assign rd_req_v     = {rd_req_1, rd_req_0};
    assign wr_req_v     = {wr_req_1, wr_req_0};
    assign rd_addr_a[0] = rd_addr_0;
    assign rd_addr_a[1] = rd_addr_1;
    assign wr_addr_a[0] = wr_addr_0;
    assign wr_addr_a[1] = wr_addr_1;
    assign wr_data_a[0] = wr_data_0;
    assign wr_data_a[1] = wr_data_1;

    rr_arbiter2 u_wr_arb (
        .clk (clk),
        .rst (rst),
        .req (wr_req_v),
        .gnt (wr_gnt_raw)
    );

    always_comb begin
        wen_raw   = 1'b0;
        waddr_raw = '0;
        wdata_raw = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (wr_gnt_raw[i]) begin
                wen_raw   = 1'b1;
                waddr_raw = wr_addr_a[i];
                wdata_raw = wr_data_a[i];
            end
        end
    end

    // A read is held off while a write to its address is issuing now or still
    // waiting for the RAM to commit it (issued last cycle).
    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_req
            assign rd_elig[gi] = rd_req_v[gi]
                && !(wen_raw && (rd_addr_a[gi] == waddr_raw))
                && !(lw_valid_reg && (rd_addr_a[gi] == lw_addr_reg));
            assign rd_rdata_a[gi] = rv_reg[gi] ? rdata_0 : '0;
        end
    endgenerate

    rr_arbiter2 u_rd_arb (
        .clk (clk),
        .rst (rst),
        .req (rd_elig),
        .gnt (rd_gnt_raw)
    );

    always_comb begin
        raddr_raw = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (rd_gnt_raw[i]) begin
                raddr_raw = rd_addr_a[i];
            end
        end
    end

    assign rv_next       = rd_gnt_raw;
    assign lw_valid_next = wen_raw;
    assign lw_addr_next  = waddr_raw;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rv_reg       <= '0;
            lw_valid_reg <= 1'b0;
            lw_addr_reg  <= '0;
        end else begin
            rv_reg       <= rv_next;
            lw_valid_reg <= lw_valid_next;
            lw_addr_reg  <= lw_addr_next;
        end
    end

    // Combinational outputs are forced quiet for the whole time reset is low.
    always_comb begin
        rd_gnt_0 = 1'b0;
        rd_gnt_1 = 1'b0;
        wr_gnt_0 = 1'b0;
        wr_gnt_1 = 1'b0;
        ren_0    = 1'b0;
        raddr_0  = '0;
        wen_0    = 1'b0;
        waddr_0  = '0;
        wdata_0  = '0;
        if (rst) begin
            rd_gnt_0 = rd_gnt_raw[0];
            rd_gnt_1 = rd_gnt_raw[1];
            wr_gnt_0 = wr_gnt_raw[0];
            wr_gnt_1 = wr_gnt_raw[1];
            ren_0    = |rd_gnt_raw;
            raddr_0  = raddr_raw;
            wen_0    = wen_raw;
            waddr_0  = waddr_raw;
            wdata_0  = wdata_raw;
        end
    end

    assign rd_rvalid_0 = rv_reg[0];
    assign rd_rvalid_1 = rv_reg[1];
    assign rd_rdata_0  = rd_rdata_a[0];
    assign rd_rdata_1  = rd_rdata_a[1];
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Arbiter paired with a 1R/1W 32x32 RAM model (write commits one cycle late);
// read responses are checked through a scoreboard queue.
module tb_ram_port_arbiter;
    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rd_req_0 = 1'b0, rd_req_1 = 1'b0;
    logic [AW-1:0] rd_addr_0 = '0, rd_addr_1 = '0;
    logic          rd_gnt_0, rd_gnt_1, rd_rvalid_0, rd_rvalid_1;
    logic [DW-1:0] rd_rdata_0, rd_rdata_1;
    logic          wr_req_0 = 1'b0, wr_req_1 = 1'b0;
    logic [AW-1:0] wr_addr_0 = '0, wr_addr_1 = '0;
    logic [DW-1:0] wr_data_0 = '0, wr_data_1 = '0;
    logic          wr_gnt_0, wr_gnt_1;
    logic [AW-1:0] raddr_0, waddr_0;
    logic [DW-1:0] wdata_0;
    logic          ren_0, wen_0;
    logic [DW-1:0] rdata_0;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int            req;
        logic [DW-1:0] data;
    } exp_t;
    exp_t sb_q[$];

    always #5 clk = ~clk;

    ram_port_arbiter #(.NREQ(2), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .rd_req_0(rd_req_0), .rd_addr_0(rd_addr_0), .rd_gnt_0(rd_gnt_0),
        .rd_rvalid_0(rd_rvalid_0), .rd_rdata_0(rd_rdata_0),
        .rd_req_1(rd_req_1), .rd_addr_1(rd_addr_1), .rd_gnt_1(rd_gnt_1),
        .rd_rvalid_1(rd_rvalid_1), .rd_rdata_1(rd_rdata_1),
        .wr_req_0(wr_req_0), .wr_addr_0(wr_addr_0), .wr_data_0(wr_data_0), .wr_gnt_0(wr_gnt_0),
        .wr_req_1(wr_req_1), .wr_addr_1(wr_addr_1), .wr_data_1(wr_data_1), .wr_gnt_1(wr_gnt_1),
        .raddr_0(raddr_0), .ren_0(ren_0), .rdata_0(rdata_0),
        .waddr_0(waddr_0), .wdata_0(wdata_0), .wen_0(wen_0)
    );

    // RAM model: registered read, write staged one cycle before commit
    logic [DW-1:0] mem [32];
    logic          preload = 1'b1;
    logic          wp_v = 1'b0;
    logic [AW-1:0] wp_a = '0;
    logic [DW-1:0] wp_d = '0;
    logic [AW-1:0] dbg_addr = '0;
    logic [DW-1:0] dbg_data;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'hA000_0000 + i;
        end else if (wp_v) begin
            mem[wp_a] <= wp_d;
        end
        if (ren_0) rdata_0 <= mem[raddr_0];
        wp_v <= wen_0;
        wp_a <= waddr_0;
        wp_d <= wdata_0;
    end
    assign dbg_data = mem[dbg_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h (t=%0t)", name, act, $time);
        end
    endtask

    task automatic mon_port(input int r, input logic v, input logic [DW-1:0] d);
        exp_t e;
        if (v) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_rvalid_req%0d: got rvalid=1 data=%h, required rvalid=0 (t=%0t)",
                         r, d, $time);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("rvalid_owner_req%0d", r), r, e.req);
                chk($sformatf("rdata_req%0d", r), d, e.data);
            end
        end else begin
            chk($sformatf("rdata_idle_req%0d", r), d, 32'h0);
        end
    endtask

    always @(negedge clk) begin
        mon_port(0, rd_rvalid_0, rd_rdata_0);
        mon_port(1, rd_rvalid_1, rd_rdata_1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic push(input int r, input logic [DW-1:0] d);
        exp_t e;
        e.req  = r;
        e.data = d;
        sb_q.push_back(e);
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1);
    end

    initial begin
        // Reset: requests asserted, nothing may leak out
        rd_req_0 = 1'b1; rd_addr_0 = 5'd3; wr_req_0 = 1'b1; wr_addr_0 = 5'd6; wr_data_0 = 32'h55;
        step(); step(); settle();
        chk("rst_rd_gnt_0", rd_gnt_0, 0);
        chk("rst_wr_gnt_0", wr_gnt_0, 0);
        chk("rst_ren_0",    ren_0, 0);
        chk("rst_raddr_0",  raddr_0, 0);
        chk("rst_wen_0",    wen_0, 0);
        chk("rst_wdata_0",  wdata_0, 0);
        chk("rst_rvalid_0", rd_rvalid_0, 0);
        step();
        preload = 1'b0; rd_req_0 = 1'b0; wr_req_0 = 1'b0;
        rst = 1'b1;

        // Both read continuously: 0,1,0,1,...
        rd_req_0 = 1'b1; rd_addr_0 = 5'd3;
        rd_req_1 = 1'b1; rd_addr_1 = 5'd7;
        for (int k = 0; k < 6; k++) begin
            settle();
            chk($sformatf("rr_gnt0_k%0d", k), rd_gnt_0, (k % 2 == 0) ? 1 : 0);
            chk($sformatf("rr_gnt1_k%0d", k), rd_gnt_1, (k % 2 == 1) ? 1 : 0);
            chk($sformatf("rr_raddr_k%0d", k), raddr_0, (k % 2 == 0) ? 3 : 7);
            push(k % 2, (k % 2 == 0) ? 32'hA000_0003 : 32'hA000_0007);
            step();
        end
        rd_req_0 = 1'b0; rd_req_1 = 1'b0;
        settle();
        chk("idle_ren", ren_0, 0);
        step();

        // RAW hazard: write addr 4 = 17 with read of addr 4 in the same cycle
        wr_req_0 = 1'b1; wr_addr_0 = 5'd4; wr_data_0 = 32'd17;
        rd_req_1 = 1'b1; rd_addr_1 = 5'd4;
        settle();
        chk("raw_t_wr_gnt0", wr_gnt_0, 1);
        chk("raw_t_waddr",   waddr_0, 4);
        chk("raw_t_wdata",   wdata_0, 17);
        chk("raw_t_rd_gnt1", rd_gnt_1, 0);
        chk("raw_t_ren",     ren_0, 0);
        step();
        wr_req_0 = 1'b0;
        settle();
        chk("raw_t1_rd_gnt1", rd_gnt_1, 0);
        step();
        settle();
        chk("raw_t2_rd_gnt1", rd_gnt_1, 1);
        chk("raw_t2_raddr",   raddr_0, 4);
        push(1, 32'd17);
        step();
        rd_req_1 = 1'b0;

        // Different address: no stall
        wr_req_0 = 1'b1; wr_addr_0 = 5'd4; wr_data_0 = 32'd18;
        rd_req_1 = 1'b1; rd_addr_1 = 5'd5;
        settle();
        chk("nohaz_wr_gnt0", wr_gnt_0, 1);
        chk("nohaz_rd_gnt1", rd_gnt_1, 1);
        chk("nohaz_raddr",   raddr_0, 5);
        push(1, 32'hA000_0005);
        step();
        wr_req_0 = 1'b0; rd_req_1 = 1'b0;

        // Lone write from requester 1 returns the write pointer to 0
        wr_req_1 = 1'b1; wr_addr_1 = 5'd10; wr_data_1 = 32'd55;
        settle();
        chk("lone_wr_gnt1", wr_gnt_1, 1);
        step();
        wr_req_1 = 1'b0;

        // Simultaneous writes to addr 9
        wr_req_0 = 1'b1; wr_addr_0 = 5'd9; wr_data_0 = 32'd1;
        wr_req_1 = 1'b1; wr_addr_1 = 5'd9; wr_data_1 = 32'd2;
        settle();
        chk("dual_wr_gnt0", wr_gnt_0, 1);
        chk("dual_wr_gnt1", wr_gnt_1, 0);
        chk("dual_wdata_a", wdata_0, 1);
        step();
        wr_req_0 = 1'b0;
        settle();
        chk("dual_wr_gnt1_next", wr_gnt_1, 1);
        chk("dual_waddr_b",      waddr_0, 9);
        chk("dual_wdata_b",      wdata_0, 2);
        step();
        wr_req_1 = 1'b0;
        step(); step();
        dbg_addr = 5'd9;  #1; chk("mem9",  dbg_data, 2);
        dbg_addr = 5'd10; #1; chk("mem10", dbg_data, 55);
        dbg_addr = 5'd4;  #1; chk("mem4",  dbg_data, 18);
        step();

        // Reset during an outstanding read grant
        rd_req_0 = 1'b1; rd_addr_0 = 5'd3;
        wr_req_0 = 1'b1; wr_addr_0 = 5'd7; wr_data_0 = 32'd99;
        settle();
        chk("pre_rst_rd_gnt0", rd_gnt_0, 1);
        chk("pre_rst_wr_gnt0", wr_gnt_0, 1);
        push(0, 32'hA000_0003);
        step();
        wr_req_0 = 1'b0;
        settle();
        chk("rst_cycle_rd_gnt0", rd_gnt_0, 1);
        #3;
        rst = 1'b0;
        #1;
        chk("in_rst_rd_gnt0", rd_gnt_0, 0);
        chk("in_rst_ren",     ren_0, 0);
        chk("in_rst_rvalid0", rd_rvalid_0, 0);
        step(); step();
        rst = 1'b1;
        rd_req_0 = 1'b1; rd_addr_0 = 5'd3;
        rd_req_1 = 1'b1; rd_addr_1 = 5'd7;
        settle();
        chk("post_rst_gnt0", rd_gnt_0, 1);
        chk("post_rst_gnt1", rd_gnt_1, 0);
        push(0, 32'hA000_0003);
        step();
        settle();
        chk("post_rst_gnt1_next", rd_gnt_1, 1);
        push(1, 32'd99);
        step();
        rd_req_0 = 1'b0; rd_req_1 = 1'b0;
        step(); step();

        chk("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ram_port_arbiter.md
RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

Interface
REQ-001 Parameter NREQ, default 2, number of requesters; only value 2 is supported.
REQ-002 Parameter ADDR_W, default 5, RAM word address width.
REQ-003 Parameter DATA_W, default 32, RAM data width.
REQ-004 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low (rst=0 resets).
REQ-006 rd_req_n  in  1 (n=0,1)  requester n read request, held until granted.
REQ-007 rd_addr_n  in  ADDR_W  requester n read address.
REQ-008 rd_gnt_n  out  1  read accepted this cycle (combinational).
REQ-009 rd_rvalid_n  out  1  read data valid for requester n.
REQ-010 rd_rdata_n  out  DATA_W  read data for requester n.
REQ-011 wr_req_n  in  1  requester n write request, held until granted.
REQ-012 wr_addr_n / wr_data_n  in  ADDR_W / DATA_W  write address and data.
REQ-013 wr_gnt_n  out  1  write accepted this cycle (combinational).
REQ-014 raddr_0 / ren_0  out  ADDR_W / 1  RAM read port.
REQ-015 rdata_0  in  DATA_W  RAM read data, registered, valid one cycle after ren_0.
REQ-016 waddr_0 / wdata_0 / wen_0  out  ADDR_W / DATA_W / 1  RAM write port; RAM commits one cycle after issue.

Function
REQ-017 Read and write ports SHALL be arbitrated independently, each by its own round-robin pointer.
REQ-018 Per port: at most one grant per cycle; a lone eligible requester is granted; if both are eligible, the one the pointer names is granted.
REQ-019 After a grant, the pointer SHALL name the other requester from the next cycle; with no grant it holds.
REQ-020 A granted read drives ren_0=1 and raddr_0=rd_addr_n in the same cycle; otherwise ren_0=0, raddr_0=0.
REQ-021 A granted write drives wen_0=1, waddr_0, wdata_0 in the same cycle; otherwise wen_0=0, waddr_0=0, wdata_0=0.
REQ-022 Read latency SHALL be 1: the cycle after a read grant, rd_rvalid_n=1 for the granted requester only, rd_rdata_n=rdata_0; both rvalids 0 otherwise; rd_rdata_n SHALL be 0 whenever rd_rvalid_n=0.
REQ-023 RAW hazard: a read whose address equals the address of a write granted in the same cycle or the previous cycle SHALL be ineligible (no grant) that cycle.
REQ-024 A hazard-stalled requester SHALL not block the other read requester; the pointer does not advance for a stall.
REQ-025 Same-cycle writes from both requesters are serialized by REQ-018; the loser stays pending with wr_gnt_n=0.
REQ-026 Throughput: one read and one write grant SHALL be possible every cycle with no bubbles absent hazards.

Reset
REQ-027 While rst=0: all outputs 0, both pointers name requester 0, read-pending and last-write trackers cleared.
REQ-028 A read granted in the cycle before reset asserts SHALL produce no rvalid after reset releases.
REQ-029 The first cycle after release SHALL see no RAW hazard from pre-reset writes.

Structure
REQ-030 Package ram_arb_pkg SHALL hold ADDR_W, DATA_W, NREQ defaults and the requester-index type.
REQ-031 Sub-module rr_arbiter2 (2-way round-robin: req[1:0] -> gnt[1:0], pointer state) SHALL be instantiated twice, once per port.

Verification
REQ-032 Bench pairs the block with the 1R/1W 32x32 RAM (1-cycle write delay) and checks via the RAM debug port.
REQ-033 Both read continuously, addresses 3 and 7, RAM preloaded -> grants alternate 0,1,0,1 starting with 0; each rvalid one cycle after its grant with correct data.
REQ-034 Req0 writes addr 4 = 17 in cycle t; req1 reads addr 4 in t -> no grant in t or t+1, grant in t+2, rdata=17.
REQ-035 Same as REQ-034 but the read is addr 5 -> granted in t, no stall.
REQ-036 Both write addr 9 (values 1, 2) simultaneously -> req0 granted first, req1 next cycle; final mem[9]=2.
REQ-037 Read granted, rst pulled low before the next edge -> no rvalid after release; first grant goes to requester 0.
